// File: rtl/qmath_pkg.sv
// Shared definitions for the fixed-point handshake divider: FSM encoding and sizing helpers.
package qmath_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } qdiv_state_t;

    // Iteration counter width and accept-to-valid latency for an N-bit, Q-fraction divider.
    function automatic int cnt_width(input int n, input int q);
        return $clog2(n + q);
    endfunction

    function automatic int latency(input int n, input int q);
        return n + q + 1;
    endfunction

    localparam int QDIV_N_DEF = 32;
    localparam int QDIV_Q_DEF = 15;
    localparam int CNT_W      = cnt_width(QDIV_N_DEF, QDIV_Q_DEF);
    localparam int LAT        = latency(QDIV_N_DEF, QDIV_Q_DEF);

endpackage

// File: rtl/qdiv_step.sv
// One restoring-division step: shift a dividend bit into the remainder, subtract if it fits.
module qdiv_step
#(
    parameter int N = 32
)
(
    input  logic [N-1:0] rem,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0] trial;
    logic [N:0] diff;
    logic       fits;

    // Remainder is always below the divisor, so both outcomes fit back into N bits.
    always_comb begin
        trial    = {rem, bit_in};
        diff     = trial - {1'b0, divisor};
        fits     = (trial >= {1'b0, divisor});
        q_bit    = fits;
        rem_next = fits ? diff[N-1:0] : trial[N-1:0];
    end

endmodule

// File: rtl/qdiv_hs.sv
// Signed Q-format divider with valid/ready handshake on both sides.
// Magnitudes are divided bit-serially, then rounded, signed and range-checked.
//
//   state | meaning
//   IDLE  | o_ready high, waiting for an operand pair
//   DIV   | one restoring step per cycle, MSB first, N+Q steps
//   FIX   | rounding, sign, overflow / divide-by-zero result
//   DONE  | o_valid high, result held until i_ready
module qdiv_hs
    import qmath_pkg::*;
#(
    parameter int N     = 32,
    parameter int Q     = 15,
    parameter int ROUND = 0,
    parameter int SAT   = 1
)
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_quotient,
    output logic         o_overflow,
    output logic         o_dbz
);

    localparam int QW = N + Q;
    localparam int CW = cnt_width(N, Q);

    localparam logic [CW-1:0] CNT_LOAD = CW'(QW - 1);
    localparam logic [QW:0]   LIM_POS  = (QW+1)'((64'd1 << (N - 1)) - 64'd1);
    localparam logic [QW:0]   LIM_NEG  = LIM_POS + (QW+1)'(1);
    localparam logic [N-1:0]  Q_MAX    = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  Q_MIN    = {1'b1, {(N-1){1'b0}}};

    qdiv_state_t   state;
    logic [CW-1:0] cnt;
    logic [QW-1:0] dvd_sh;
    logic [QW-1:0] quo;
    logic [N-1:0]  rem;
    logic [N-1:0]  dvs_mag;
    logic          res_neg;
    logic          dvd_neg;
    logic          dbz_pend;

    logic [N-1:0]  dvd_abs;
    logic [N-1:0]  dvs_abs;
    logic [N-1:0]  rem_next;
    logic          q_bit;

    logic          round_up;
    logic [QW:0]   mag_rnd;
    logic          ov_det;
    logic [N-1:0]  wrap_q;
    logic [N-1:0]  fix_q;

    // N-bit unsigned magnitudes keep -2^(N-1) exact.
    assign dvd_abs = i_dividend[N-1] ? (~i_dividend + N'(1)) : i_dividend;
    assign dvs_abs = i_divisor[N-1]  ? (~i_divisor  + N'(1)) : i_divisor;

    qdiv_step #(.N(N)) u_step (
        .rem      (rem),
        .bit_in   (dvd_sh[QW-1]),
        .divisor  (dvs_mag),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        round_up = (ROUND != 0) && ({rem, 1'b0} >= {1'b0, dvs_mag});
        mag_rnd  = {1'b0, quo} + {{QW{1'b0}}, round_up};
        ov_det   = res_neg ? (mag_rnd > LIM_NEG) : (mag_rnd > LIM_POS);
        wrap_q   = res_neg ? (~mag_rnd[N-1:0] + N'(1)) : mag_rnd[N-1:0];
        if (ov_det && (SAT != 0)) begin
            fix_q = res_neg ? Q_MIN : Q_MAX;
        end else begin
            fix_q = wrap_q;
        end
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dvd_sh     <= '0;
            quo        <= '0;
            rem        <= '0;
            dvs_mag    <= '0;
            res_neg    <= 1'b0;
            dvd_neg    <= 1'b0;
            dbz_pend   <= 1'b0;
            o_quotient <= '0;
            o_overflow <= 1'b0;
            o_dbz      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        dvd_neg  <= i_dividend[N-1];
                        res_neg  <= i_dividend[N-1] ^ i_divisor[N-1];
                        dvd_sh   <= QW'(dvd_abs) << Q;
                        dvs_mag  <= dvs_abs;
                        rem      <= '0;
                        quo      <= '0;
                        dbz_pend <= (i_divisor == '0);
                        if (i_divisor == '0) begin
                            state <= FIX;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem    <= rem_next;
                    quo    <= {quo[QW-2:0], q_bit};
                    dvd_sh <= {dvd_sh[QW-2:0], 1'b0};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    if (dbz_pend) begin
                        o_quotient <= dvd_neg ? Q_MIN : Q_MAX;
                        o_overflow <= 1'b0;
                        o_dbz      <= 1'b1;
                    end else begin
                        o_quotient <= fix_q;
                        o_overflow <= ov_det;
                        o_dbz      <= 1'b0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qdiv_hs.sv
// Scoreboard bench for qdiv_hs (N=16, Q=8): truncate/saturate and round/wrap instances in parallel.
module tb_qdiv_hs;

    localparam int N = 16;
    localparam int Q = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  dvd;
    logic [N-1:0]  dvs;

    logic          rdy0, vld0, ov0, dbz0;
    logic [N-1:0]  q0;
    logic          rdy1, vld1, ov1, dbz1;
    logic [N-1:0]  q1;

    always #5 clk = ~clk;

    qdiv_hs #(.N(N), .Q(Q), .ROUND(0), .SAT(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy0),
        .i_dividend(dvd), .i_divisor(dvs), .o_valid(vld0), .i_ready(in_ready),
        .o_quotient(q0), .o_overflow(ov0), .o_dbz(dbz0)
    );

    qdiv_hs #(.N(N), .Q(Q), .ROUND(1), .SAT(0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy1),
        .i_dividend(dvd), .i_divisor(dvs), .o_valid(vld1), .i_ready(in_ready),
        .o_quotient(q1), .o_overflow(ov1), .o_dbz(dbz1)
    );

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q0;
        logic        ov0;
        logic        dbz0;
        logic [15:0] q1;
        logic        ov1;
        logic        dbz1;
        int          stall;
    } vec_t;

    typedef struct {
        vec_t v;
        int   idx;
        int   acc;
        int   lat;
    } exp_t;

    // dut0: ROUND=0 SAT=1 expectations, dut1: ROUND=1 SAT=0 expectations (hand-computed)
    vec_t vecs [12] = '{
        '{16'h0180, 16'h0080, 16'h0300, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 0},
        '{16'hFF00, 16'h0400, 16'hFFC0, 1'b0, 1'b0, 16'hFFC0, 1'b0, 1'b0, 0},
        '{16'h0200, 16'h0300, 16'h00AA, 1'b0, 1'b0, 16'h00AB, 1'b0, 1'b0, 10},
        '{16'h7F00, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0},
        '{16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0, 0},
        '{16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 0},
        '{16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 3},
        '{16'h0000, 16'h0300, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0},
        '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 0},
        '{16'hFE00, 16'h0300, 16'hFF56, 1'b0, 1'b0, 16'hFF55, 1'b0, 1'b0, 0},
        '{16'h8000, 16'h0080, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0},
        '{16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 16'h0055, 1'b0, 1'b0, 0}
    };

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %h, required %h", name, idx, act, exp);
        end
    endtask

    // Garbage operands with i_valid high are driven while the DUT is busy; they must be ignored.
    task automatic issue(input vec_t v, input int idx);
        exp_t e;
        int   w;
        in_valid = 1'b1;
        dvd      = 16'($urandom);
        dvs      = 16'($urandom);
        w        = 0;
        while (!rdy0 && w < 400) begin
            @(negedge clk);
            dvd = 16'($urandom);
            dvs = 16'($urandom);
            w++;
        end
        if (!rdy0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout (vec %0d): o_ready=0, required 1", idx);
            in_valid = 1'b0;
            return;
        end
        dvd = v.dvd;
        dvs = v.dvs;
        @(posedge clk);
        #1;
        e.v   = v;
        e.idx = idx;
        e.acc = cyc;
        e.lat = (v.dvs == 16'h0000) ? 1 : 25;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || vld0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_scoreboard", -1, sb.size(), 0);
    endtask

    exp_t m_e;
    int   m_lat;

    initial begin : monitor
        in_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && vld0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: o_valid=1 with nothing outstanding, required 0");
                    in_ready = 1'b1;
                    @(posedge clk);
                    #1 in_ready = 1'b0;
                end else begin
                    m_e   = sb.pop_front();
                    m_lat = cyc - m_e.acc;
                    chk("latency",   m_e.idx, m_lat, m_e.lat);
                    chk("q_trunc",   m_e.idx, q0,   m_e.v.q0);
                    chk("ov_trunc",  m_e.idx, ov0,  m_e.v.ov0);
                    chk("dbz_trunc", m_e.idx, dbz0, m_e.v.dbz0);
                    chk("vld_round", m_e.idx, vld1, 1);
                    chk("q_round",   m_e.idx, q1,   m_e.v.q1);
                    chk("ov_round",  m_e.idx, ov1,  m_e.v.ov1);
                    chk("dbz_round", m_e.idx, dbz1, m_e.v.dbz1);
                    chk("rdy_in_done", m_e.idx, rdy0, 0);
                    repeat (m_e.v.stall) begin
                        @(negedge clk);
                        chk("stall_vld", m_e.idx, vld0, 1);
                        chk("stall_rdy", m_e.idx, rdy0, 0);
                        chk("stall_q",   m_e.idx, {q0, q1}, {m_e.v.q0, m_e.v.q1});
                        chk("stall_flags", m_e.idx, {ov0, dbz0, ov1, dbz1},
                            {m_e.v.ov0, m_e.v.dbz0, m_e.v.ov1, m_e.v.dbz1});
                    end
                    in_ready = 1'b1;
                    @(negedge clk);
                    in_ready = 1'b0;
                    chk("post_hs_vld", m_e.idx, vld0, 0);
                    chk("post_hs_rdy", m_e.idx, rdy0, 1);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        rst      = 1'b1;
        in_valid = 1'b0;
        dvd      = '0;
        dvs      = '0;
        repeat (3) @(negedge clk);
        chk("rst_vld",   -1, {vld0, vld1}, 2'b00);
        chk("rst_q",     -1, {q0, q1}, 32'h0);
        chk("rst_flags", -1, {ov0, dbz0, ov1, dbz1}, 4'h0);
        rst = 1'b0;
        chk("rst_rdy",   -1, {rdy0, rdy1}, 2'b11);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i], i);
        end
        in_valid = 1'b0;
        drain();

        // Reset partway through DIV: the operation must vanish without an output pulse.
        dvd      = 16'h0180;
        dvs      = 16'h0080;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_before_rst", 100, rdy0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rdy_after_rst", 100, {rdy0, rdy1}, 2'b11);
        chk("vld_after_rst", 100, {vld0, vld1}, 2'b00);
        repeat (40) @(negedge clk);
        chk("idle_after_rst", 100, rdy0, 1);

        issue(vecs[9], 101);
        issue(vecs[0], 102);
        in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qdiv_hs.md
QDIV_HS -- requirements
Module: qdiv_hs

Interface
REQ-001 SHALL have parameter N, default 32: total word width incl. sign bit, two's complement, range 4..64.
REQ-002 SHALL have parameter Q, default 15: fraction bits, range 0..N-2.
REQ-003 SHALL have parameter ROUND, default 0: 0 = truncate toward zero, 1 = round half away from zero.
REQ-004 SHALL have parameter SAT, default 1: 1 = saturate on overflow, 0 = keep low N bits (wrap).
REQ-005 SHALL have port i_clk, input, 1: the single clock; all logic on the rising edge.
REQ-006 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port i_valid, input, 1: operand pair offered.
REQ-008 SHALL have port o_ready, output, 1: block accepts operands this cycle.
REQ-009 SHALL have port i_dividend, input, N: signed Q-format dividend.
REQ-010 SHALL have port i_divisor, input, N: signed Q-format divisor.
REQ-011 SHALL have port o_valid, output, 1: result held on the outputs.
REQ-012 SHALL have port i_ready, input, 1: consumer takes the result.
REQ-013 SHALL have port o_quotient, output, N: signed Q-format quotient.
REQ-014 SHALL have port o_overflow, output, 1: true result was outside the range.
REQ-015 SHALL have port o_dbz, output, 1: divisor was zero.

Function
REQ-016 SHALL implement FSM states IDLE, DIV, FIX, DONE; o_ready = (state==IDLE); o_valid = (state==DONE).
REQ-017 SHALL accept when i_valid && o_ready: latch operands and signs; capture |dividend| and |divisor| as N-bit unsigned, so that -2^(N-1) is handled exactly.
REQ-018 SHALL go IDLE->DIV on acceptance with a nonzero divisor, loading an iteration counter with N+Q-1.
REQ-019 SHALL go IDLE->FIX on acceptance with a zero divisor, skipping DIV.
REQ-020 SHALL, in DIV, perform one restoring-division step per cycle on (|dividend| << Q) / |divisor|: one quotient bit per cycle, MSB first, for N+Q cycles, keeping the partial remainder.
REQ-021 SHALL go DIV->FIX on the cycle the counter is 0.
REQ-022 SHALL, in FIX with ROUND=1, add 1 to the magnitude when 2*remainder >= |divisor|.
REQ-023 SHALL, in FIX, apply the sign (dividend sign XOR divisor sign) and check range: positive magnitude > 2^(N-1)-1, or negative magnitude > 2^(N-1), sets o_overflow.
REQ-024 SHALL, on overflow with SAT=1, output 2^(N-1)-1 or -2^(N-1) by sign; with SAT=0, output the low N bits of the signed result.
REQ-025 SHALL, on divide-by-zero, set o_dbz=1 and o_overflow=0; o_quotient = 2^(N-1)-1 if dividend >= 0, else -2^(N-1), regardless of SAT.
REQ-026 SHALL go FIX->DONE unconditionally and register all outputs there.
REQ-027 SHALL give latency from the acceptance edge to o_valid high of N+Q+1 cycles normally and 1 cycle for divide-by-zero.
REQ-028 SHALL hold o_quotient, o_overflow and o_dbz stable while o_valid && !i_ready.
REQ-029 SHALL go DONE->IDLE on o_valid && i_ready; o_ready SHALL not rise until the following cycle, so there is no same-cycle accept.
REQ-030 SHALL ignore i_valid and operand changes outside IDLE.
REQ-031 SHALL give a zero dividend a quotient of 0 with no flags.

Reset
REQ-032 SHALL, while i_rst is high on a clock edge: state=IDLE, o_valid=0, o_quotient=0, o_overflow=0, o_dbz=0, counter=0; o_ready SHALL be 1 on the first cycle after reset.
REQ-033 SHALL, on reset in any state (including mid-DIV or DONE with a pending result), abandon the operation with no output pulse.

Structure
REQ-034 SHALL take the FSM state encoding and localparams (counter width $clog2(N+Q), LAT = N+Q+1) from shared package qmath_pkg.
REQ-035 SHALL place the single restoring step (compare, subtract, shift, quotient bit) in combinational sub-module qdiv_step, instantiated once.

Verification (N=16, Q=8 unless stated)
REQ-036 SHALL check 0x0180 / 0x0080 -> 0x0300, flags 0, o_valid exactly 25 cycles after accept; 0xFF00 / 0x0400 -> 0xFFC0.
REQ-037 SHALL check 0x0200 / 0x0300 -> 0x00AA with ROUND=0 and 0x00AB with ROUND=1.
REQ-038 SHALL check 0x7F00 / 0x0001 -> 0x7FFF with o_overflow=1 (SAT=1); 0x8000 / 0xFF00 -> 0x7FFF with o_overflow=1.
REQ-039 SHALL check 0x0100 / 0x0000 -> 0x7FFF with o_dbz=1, and 0xFF00 / 0x0000 -> 0x8000 with o_dbz=1, each 1 cycle after accept.
REQ-040 SHALL check backpressure: i_ready held low 10 cycles keeps outputs stable and o_ready low; back-to-back operations follow on release.
REQ-041 SHALL check i_rst asserted mid-DIV: o_valid never rises, o_ready=1 the next cycle, and a new operation completes correctly.
